// File: rtl/approx_mult_error_monitor_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// FSM encoding, default sizing and saturating accumulate helpers.
package approx_mult_error_monitor_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 17;
  localparam int DEF_ACC_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Unsigned add clamped to the all-ones value of a w-bit accumulator (w <= 63).
  function automatic logic [63:0] sat_add_u(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int unsigned w);
    logic [64:0] sum;
    logic [64:0] maxv;
    maxv = (65'd1 << w) - 65'd1;
    sum  = {1'b0, acc} + {1'b0, inc};
    if (sum > maxv) begin
      return maxv[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

  // Two's complement add clamped to the signed range of a w-bit accumulator.
  function automatic logic signed [63:0] sat_add_s(input logic signed [63:0] acc,
                                                   input logic signed [63:0] inc,
                                                   input int unsigned w);
    logic signed [64:0] sum;
    logic signed [64:0] maxv;
    logic signed [64:0] minv;
    maxv = (65'sd1 <<< (w - 32'd1)) - 65'sd1;
    minv = -maxv - 65'sd1;
    sum  = 65'(acc) + 65'(inc);
    if (sum > maxv) begin
      return maxv[63:0];
    end else if (sum < minv) begin
      return minv[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/approx_mult_error_monitor_err_dist_calc.sv
// Combinational error-distance stage: exact product, signed difference
// (approx - exact) and its magnitude. Registers live in the parent.
module approx_mult_error_monitor_err_dist_calc
  import approx_mult_error_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [2*WIDTH-1:0]        p_approx,
  output logic signed [2*WIDTH:0]   diff,
  output logic [2*WIDTH-1:0]        ed
);

  logic [2*WIDTH-1:0] p_exact_s;
  logic signed [2*WIDTH:0] neg_diff_s;

  assign p_exact_s  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign diff       = signed'({1'b0, p_approx}) - signed'({1'b0, p_exact_s});
  assign neg_diff_s = -diff;
  // |diff| never exceeds 2^(2*WIDTH)-1, so the sign bit can be dropped.
  assign ed         = diff[2*WIDTH] ? neg_diff_s[2*WIDTH-1:0] : diff[2*WIDTH-1:0];

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Streams (A, B, P_Approx) samples through a 3-stage pipeline and accumulates
// error count, summed/max error distance and signed bias over a programmed run.
module approx_mult_error_monitor
  import approx_mult_error_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [CNT_W-1:0]     Num_Samples,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   P_Approx,
  output logic                 Busy,
  output logic                 Done,
  output logic [CNT_W-1:0]     Sample_Count,
  output logic [CNT_W-1:0]     Err_Count,
  output logic [ACC_W-1:0]     Sum_ED,
  output logic [2*WIDTH-1:0]   Max_ED,
  output logic [ACC_W-1:0]     Bias
);

  localparam int PW = 2*WIDTH;

  state_t state_r, state_nx_s;
  logic [CNT_W-1:0] num_r;
  logic in_ready_r, busy_r, done_r;
  logic accept_s, clr_s;

  logic [WIDTH-1:0] a1_r, b1_r;
  logic [PW-1:0] p1_r;
  logic v1_r;
  logic signed [PW:0] diff_s, diff2_r;
  logic [PW-1:0] ed_s, ed2_r;
  logic v2_r;

  logic [CNT_W-1:0] cnt_r, err_r;
  logic [ACC_W-1:0] sum_r;
  logic [PW-1:0] max_r;
  logic signed [ACC_W-1:0] bias_r;

  assign accept_s = In_Valid && in_ready_r;
  assign clr_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && Start;

  // Next-state decode; a run ends on the accept that reaches the latched count.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_nx_s = (Num_Samples == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_RUN: begin
        if (accept_s && ((cnt_r + CNT_W'(1)) == num_r)) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!v1_r) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state and status outputs, registered from the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      num_r      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == ST_RUN);
      busy_r     <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DRAIN);
      done_r     <= (state_nx_s == ST_DONE);
      if (clr_s) begin
        num_r <= Num_Samples;
      end
    end
  end

  approx_mult_error_monitor_err_dist_calc #(.WIDTH(WIDTH)) u_err_dist_calc (
    .a        (a1_r),
    .b        (b1_r),
    .p_approx (p1_r),
    .diff     (diff_s),
    .ed       (ed_s)
  );

  // S1 operand capture and S2 error-distance registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      v1_r    <= 1'b0;
      a1_r    <= {WIDTH{1'b0}};
      b1_r    <= {WIDTH{1'b0}};
      p1_r    <= {PW{1'b0}};
      v2_r    <= 1'b0;
      diff2_r <= {(PW+1){1'b0}};
      ed2_r   <= {PW{1'b0}};
    end else begin
      v1_r <= accept_s;
      if (accept_s) begin
        a1_r <= A;
        b1_r <= B;
        p1_r <= P_Approx;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        diff2_r <= diff_s;
        ed2_r   <= ed_s;
      end
    end
  end

  // S3 statistics; Start clears them for a fresh run.
  always_ff @(posedge Clk) begin
    if (Rst || clr_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      err_r  <= {CNT_W{1'b0}};
      sum_r  <= {ACC_W{1'b0}};
      max_r  <= {PW{1'b0}};
      bias_r <= {ACC_W{1'b0}};
    end else begin
      if (accept_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (v2_r) begin
        err_r  <= err_r + {{(CNT_W-1){1'b0}}, (ed2_r != {PW{1'b0}})};
        sum_r  <= ACC_W'(sat_add_u(64'(sum_r), 64'(ed2_r), ACC_W));
        bias_r <= ACC_W'(sat_add_s(64'(bias_r), 64'(diff2_r), ACC_W));
        if (ed2_r > max_r) begin
          max_r <= ed2_r;
        end
      end
    end
  end

  assign In_Ready     = in_ready_r;
  assign Busy         = busy_r;
  assign Done         = done_r;
  assign Sample_Count = cnt_r;
  assign Err_Count    = err_r;
  assign Sum_ED       = sum_r;
  assign Max_ED       = max_r;
  assign Bias         = bias_r;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Bench for approx_mult_error_monitor: directed and randomised runs on a
// 32-bit-accumulator instance and a 16-bit one fed the same stream.
module tb_approx_mult_error_monitor;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Start = 1'b0;
  logic [16:0] Num_Samples = 17'd0;
  logic In_Valid = 1'b0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [15:0] P_Approx = 16'd0;

  logic rdy32, busy32, done32, rdy16, busy16, done16;
  logic [16:0] cnt32, err32, cnt16, err16;
  logic [31:0] sum32;
  logic signed [31:0] bias32;
  logic [15:0] sum16, max32, max16;
  logic signed [15:0] bias16;

  int checks = 0;
  int failures = 0;
  int unsigned qa[$], qb[$], qp[$];

  always #5 Clk = ~Clk;

  approx_mult_error_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(32)) dut32 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Num_Samples(Num_Samples),
    .In_Valid(In_Valid), .In_Ready(rdy32), .A(A), .B(B), .P_Approx(P_Approx),
    .Busy(busy32), .Done(done32), .Sample_Count(cnt32), .Err_Count(err32),
    .Sum_ED(sum32), .Max_ED(max32), .Bias(bias32)
  );

  approx_mult_error_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(16)) dut16 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Num_Samples(Num_Samples),
    .In_Valid(In_Valid), .In_Ready(rdy16), .A(A), .B(B), .P_Approx(P_Approx),
    .Busy(busy16), .Done(done16), .Sample_Count(cnt16), .Err_Count(err16),
    .Sum_ED(sum16), .Max_ED(max16), .Bias(bias16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference statistics over the first n queued samples for a given accumulator width.
  function automatic void model(input int n, input int accw, output longint errc,
                                output longint sum, output longint mx, output longint bias);
    longint ex, d, ed, smax, bmax, bmin;
    smax = (64'sd1 <<< accw) - 64'sd1;
    bmax = (64'sd1 <<< (accw - 1)) - 64'sd1;
    bmin = -bmax - 64'sd1;
    errc = 0; sum = 0; mx = 0; bias = 0;
    for (int i = 0; i < n; i++) begin
      ex = longint'(qa[i]) * longint'(qb[i]);
      d  = longint'(qp[i]) - ex;
      ed = (d < 0) ? -d : d;
      if (ed != 0) errc++;
      sum = (sum + ed > smax) ? smax : sum + ed;
      if (ed > mx) mx = ed;
      bias = bias + d;
      if (bias > bmax) bias = bmax;
      if (bias < bmin) bias = bmin;
    end
  endfunction

  task automatic gen(input int n);
    int unsigned a, b, ex, p;
    qa.delete(); qb.delete(); qp.delete();
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(255); b = $urandom_range(255); ex = a * b;
      case ($urandom_range(2))
        0: p = ex;
        1: begin
          p = ex + $urandom_range(300);
          if (p > 65535) p = 65535;
          if ($urandom_range(1) == 1) p = (ex > 300) ? ex - $urandom_range(300) : 0;
        end
        default: p = $urandom_range(65535);
      endcase
      qa.push_back(a); qb.push_back(b); qp.push_back(p);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt32"}, cnt32, 0);   chk({tag, "_err32"}, err32, 0);
    chk({tag, "_sum32"}, sum32, 0);   chk({tag, "_max32"}, max32, 0);
    chk({tag, "_bias32"}, bias32, 0); chk({tag, "_sum16"}, sum16, 0);
    chk({tag, "_bias16"}, bias16, 0); chk({tag, "_rdy"}, rdy32, 0);
    chk({tag, "_busy"}, busy32, 0);   chk({tag, "_done"}, done32, 0);
  endtask

  task automatic check_stats(input int n);
    longint e, s, m, b;
    model(n, 32, e, s, m, b);
    chk("fin_cnt32", cnt32, n); chk("fin_err32", err32, e);
    chk("fin_sum32", sum32, s); chk("fin_max32", max32, m);
    chk("fin_bias32", bias32, b);
    model(n, 16, e, s, m, b);
    chk("fin_cnt16", cnt16, n); chk("fin_err16", err16, e);
    chk("fin_sum16", sum16, s); chk("fin_max16", max16, m);
    chk("fin_bias16", bias16, b);
    chk("fin_done", done32, 1); chk("fin_busy", busy32, 0); chk("fin_rdy", rdy32, 0);
    chk("fin_done16", done16, 1);
  endtask

  task automatic do_run(input int n, input int gap_pct, input bit drain_start);
    int acc, cyc;
    bit v;
    Num_Samples = 17'(n); Start = 1'b1; In_Valid = 1'b0;
    step();
    Start = 1'b0;
    chk("start_cnt", cnt32, 0); chk("start_sum", sum32, 0);
    chk("start_busy", busy32, (n != 0)); chk("start_done", done32, (n == 0));
    acc = 0; cyc = 0;
    while (acc < n && cyc < n * 20 + 50) begin
      v = ($urandom_range(99) >= gap_pct);
      In_Valid = v; A = 8'(qa[acc]); B = 8'(qb[acc]); P_Approx = 16'(qp[acc]);
      chk("run_rdy", rdy32, 1);
      step();
      if (v) acc++;
      cyc++;
      chk("run_cnt", cnt32, acc);
    end
    chk("accept_budget", acc, n);
    if (n > 0) begin
      In_Valid = 1'b1;
      if (drain_start) begin
        Start = 1'b1; Num_Samples = 17'd7;
      end
      chk("drain1_rdy", rdy32, 0); chk("drain1_busy", busy32, 1); chk("drain1_done", done32, 0);
      step();
      Start = 1'b0; In_Valid = 1'($urandom_range(1));
      chk("drain2_rdy", rdy32, 0); chk("drain2_done", done32, 0);
      step();
      In_Valid = 1'b0;
    end else begin
      In_Valid = 1'b1;
      chk("zero_rdy", rdy32, 0);
      step();
      chk("zero_rdy2", rdy32, 0); chk("zero_cnt", cnt32, 0);
      In_Valid = 1'b0;
    end
    check_stats(n);
    step();
    chk("hold_done", done32, 1); chk("hold_cnt", cnt32, n);
  endtask

  initial begin
    Rst = 1'b1;
    step(); step();
    Rst = 1'b0;
    check_zero("reset");

    qa = '{3, 3, 3, 3}; qb = '{5, 5, 5, 5}; qp = '{15, 15, 15, 15};
    do_run(4, 0, 1'b0);

    qa = '{255, 10}; qb = '{255, 10}; qp = '{65017, 103};
    do_run(2, 0, 1'b0);

    gen(5);
    do_run(5, 40, 1'b0);

    qa.delete(); qb.delete(); qp.delete();
    do_run(0, 0, 1'b0);

    // Reset in RUN with two erroneous samples still in the pipeline.
    qa = '{200, 17, 1, 1, 1, 1}; qb = '{200, 33, 1, 1, 1, 1}; qp = '{0, 5, 1, 1, 1, 1};
    Num_Samples = 17'd6; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      In_Valid = 1'b1; A = 8'(qa[i]); B = 8'(qb[i]); P_Approx = 16'(qp[i]);
      step();
    end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check_zero("midrst");
    step();
    check_zero("idle1");
    step();
    check_zero("idle2");
    In_Valid = 1'b0;

    gen(3);
    do_run(3, 0, 1'b1);

    qa = '{255, 255}; qb = '{255, 255}; qp = '{0, 0};
    do_run(2, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      gen(6 + r);
      do_run(6 + r, 30, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
